// File: rtl/bnn_conv_engine.sv
// rtl/bnn_conv_engine.sv - self-sequenced XNOR/popcount binary convolution engine
// Loads a KxK kernel once, then slides a K-row window down each of M images.
module bnn_conv_engine #(
    parameter int          IMG_DIM    = 4,
    parameter int          KERNEL_DIM = 3,
    parameter int          THRESHOLD  = 5,
    parameter logic [11:0] OUT_BASE   = 12'h200
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        dut_run,
    output logic        dut_busy,
    output logic [11:0] dut_sram_read_address,
    input  logic [15:0] sram_dut_read_data,
    output logic [11:0] dut_sram_write_address,
    output logic [15:0] dut_sram_write_data,
    output logic        dut_sram_write_enable,
    output logic [11:0] dut_wmem_read_address,
    input  logic [15:0] wmem_dut_read_data
);

    localparam int OUT_DIM = IMG_DIM - KERNEL_DIM + 1;
    localparam int CW      = $clog2(KERNEL_DIM * KERNEL_DIM + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_W,
        S_LD_CNT,
        S_FILL,
        S_CALC,
        S_WRITE,
        S_SHIFT,
        S_NEXT_IMG,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic [4:0] cnt, cnt_nxt;

    logic [KERNEL_DIM-1:0] kernel [KERNEL_DIM];
    logic [IMG_DIM-1:0]    win    [KERNEL_DIM];
    logic [7:0]            m_count;
    logic [7:0]            img_idx;
    logic [11:0]           img_base;
    logic [4:0]            row;
    logic [11:0]           wr_ptr;
    logic [15:0]           out_row;

    logic [CW-1:0]         match_cnt [OUT_DIM];
    logic [15:0]           calc_row;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt is a per-state sub-step counter: it restarts at 0 on every state change,
    // which gives the one-cycle gap needed for memory read latency.
    always_comb begin
        state_nxt              = state;
        cnt_nxt                = cnt + 5'd1;
        dut_busy               = 1'b1;
        dut_sram_read_address  = '0;
        dut_sram_write_address = '0;
        dut_sram_write_data    = '0;
        dut_sram_write_enable  = 1'b0;
        dut_wmem_read_address  = '0;
        case (state)
            S_IDLE: begin
                dut_busy = 1'b0;
                cnt_nxt  = '0;
                if (dut_run) state_nxt = S_LD_W;
            end
            S_LD_W: begin
                if (cnt < 5'(KERNEL_DIM)) dut_wmem_read_address = 12'(cnt);
                else                      state_nxt = S_LD_CNT;
            end
            S_LD_CNT: begin
                if (cnt == 5'd1)
                    state_nxt = (sram_dut_read_data[7:0] == 8'd0) ? S_DONE : S_FILL;
            end
            S_FILL: begin
                if (cnt < 5'(KERNEL_DIM)) dut_sram_read_address = 12'd1 + img_base + 12'(cnt);
                else                      state_nxt = S_CALC;
            end
            S_CALC: begin
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                dut_sram_write_enable  = 1'b1;
                dut_sram_write_address = OUT_BASE + wr_ptr;
                dut_sram_write_data    = out_row;
                state_nxt = (row < 5'(OUT_DIM - 1)) ? S_SHIFT : S_NEXT_IMG;
            end
            S_SHIFT: begin
                if (cnt == 5'd0)
                    dut_sram_read_address = 12'd1 + img_base + 12'(row) + 12'(KERNEL_DIM);
                else
                    state_nxt = S_CALC;
            end
            S_NEXT_IMG: begin
                state_nxt = (({1'b0, img_idx} + 9'd1) < {1'b0, m_count}) ? S_FILL : S_DONE;
            end
            S_DONE: begin
                dut_busy  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    always_comb begin
        calc_row = '0;
        for (int c = 0; c < OUT_DIM; c++) begin
            match_cnt[c] = '0;
            for (int i = 0; i < KERNEL_DIM; i++) begin
                for (int j = 0; j < KERNEL_DIM; j++) begin
                    if (kernel[i][j] == win[i][c+j]) match_cnt[c] = match_cnt[c] + CW'(1);
                end
            end
            calc_row[c] = (int'(match_cnt[c]) >= THRESHOLD);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < KERNEL_DIM; i++) begin
                kernel[i] <= '0;
                win[i]    <= '0;
            end
            m_count  <= '0;
            img_idx  <= '0;
            img_base <= '0;
            row      <= '0;
            wr_ptr   <= '0;
            out_row  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dut_run) begin
                        img_idx  <= '0;
                        img_base <= '0;
                        row      <= '0;
                        wr_ptr   <= '0;
                    end
                end
                S_LD_W: begin
                    for (int i = 0; i < KERNEL_DIM; i++) begin
                        if (cnt == 5'(i + 1)) kernel[i] <= wmem_dut_read_data[KERNEL_DIM-1:0];
                    end
                end
                S_LD_CNT: begin
                    if (cnt == 5'd1) m_count <= sram_dut_read_data[7:0];
                end
                S_FILL: begin
                    if (cnt != 5'd0) begin
                        for (int i = 0; i < KERNEL_DIM - 1; i++) win[i] <= win[i+1];
                        win[KERNEL_DIM-1] <= sram_dut_read_data[IMG_DIM-1:0];
                    end
                end
                S_CALC: begin
                    out_row <= calc_row;
                end
                S_WRITE: begin
                    wr_ptr <= wr_ptr + 12'd1;
                end
                S_SHIFT: begin
                    if (cnt == 5'd1) begin
                        for (int i = 0; i < KERNEL_DIM - 1; i++) win[i] <= win[i+1];
                        win[KERNEL_DIM-1] <= sram_dut_read_data[IMG_DIM-1:0];
                        row <= row + 5'd1;
                    end
                end
                S_NEXT_IMG: begin
                    img_idx  <= img_idx + 8'd1;
                    img_base <= img_base + 12'(IMG_DIM);
                    row      <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
